// File: rtl/midi_voice_alloc_if.sv
// MIDI byte stream into the voice allocator: one byte per cycle when midi_valid is high.
interface midi_voice_alloc_if;
   logic [7:0] midi_word;
   logic       midi_valid;

   modport master (output midi_word, output midi_valid);
   modport slave  (input  midi_word, input  midi_valid);
endinterface

// File: rtl/midi_voice_alloc.sv
// MIDI note-on/off parser with polyphonic voice allocation (retrigger, lowest free, round-robin steal).
// Optional: define MIDI_RUNNING_STATUS_EN to keep the last status after each key/velocity pair.
module midi_voice_alloc #(
   parameter int         NVOICE    = 6,
   parameter logic [3:0] MIDI_CHAN = 4'd2
) (
   input  logic                  clk,
   input  logic                  rst,
   midi_voice_alloc_if.slave     mi,
   output logic                  midi_clk,
   output logic [NVOICE-1:0]     gate_out,
   output logic [7*NVOICE-1:0]   note_out,
   output logic [7*NVOICE-1:0]   velo_out,
   output logic                  busy_all
);
   localparam int PW = (NVOICE > 1) ? $clog2(NVOICE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_KEY, S_VEL, S_SKIP} state_t;

   state_t                   state_q, state_d;
   logic                     on_q, on_d;
   logic [6:0]               key_q, key_d;
   logic                     midi_clk_q, midi_clk_d;
   logic [PW-1:0]            steal_q, steal_d;
   logic [NVOICE-1:0]        gate_q, gate_d;
   logic [NVOICE-1:0][6:0]   note_q, note_d;
   logic [NVOICE-1:0][6:0]   velo_q, velo_d;

   logic is_rt, is_st, is_dat, chan_ok;
   logic ev_on, ev_off;

   // Realtime bytes (>= 0xF8) are transparent to everything but midi_clk.
   always_comb begin
      is_rt   = mi.midi_valid && (mi.midi_word >= 8'hF8);
      is_st   = mi.midi_valid && mi.midi_word[7] && !is_rt;
      is_dat  = mi.midi_valid && !mi.midi_word[7];
      chan_ok = (mi.midi_word[3:0] == MIDI_CHAN) &&
                ((mi.midi_word[7:4] == 4'h9) || (mi.midi_word[7:4] == 4'h8));
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // System-common status (0xF0..0xF7) falls into SKIP like any foreign status,
   // which also drops the running status.
   always_comb begin
      state_d = state_q;
      if (is_st) begin
         state_d = chan_ok ? S_KEY : S_SKIP;
      end else if (is_dat) begin
         case (state_q)
            S_KEY:   state_d = S_VEL;
`ifdef MIDI_RUNNING_STATUS_EN
            S_VEL:   state_d = S_KEY;
`else
            S_VEL:   state_d = S_IDLE;
`endif
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      ev_on  = 1'b0;
      ev_off = 1'b0;
      if (is_dat && (state_q == S_VEL)) begin
         ev_on  = on_q && (mi.midi_word[6:0] != 7'd0);
         ev_off = !ev_on;
      end
   end

   always_comb begin
      on_d       = (is_st && chan_ok) ? mi.midi_word[4] : on_q;
      key_d      = (is_dat && (state_q == S_KEY)) ? mi.midi_word[6:0] : key_q;
      midi_clk_d = mi.midi_valid && (mi.midi_word == 8'hF8);
   end

   logic [NVOICE-1:0] match;
   logic [PW-1:0]     hit_idx, free_idx, sel_idx;
   logic              hit, free;

   always_comb begin
      hit_idx  = '0;
      free_idx = '0;
      for (int i = NVOICE - 1; i >= 0; i--) begin
         match[i] = gate_q[i] && (note_q[i] == key_q);
         if (match[i])   hit_idx  = PW'(i);
         if (!gate_q[i]) free_idx = PW'(i);
      end
      hit  = |match;
      free = ~&gate_q;
      sel_idx = hit ? hit_idx : (free ? free_idx : steal_q);

      gate_d  = gate_q;
      note_d  = note_q;
      velo_d  = velo_q;
      steal_d = steal_q;
      if (ev_on) begin
         gate_d[sel_idx] = 1'b1;
         note_d[sel_idx] = key_q;
         velo_d[sel_idx] = mi.midi_word[6:0];
         if (!hit && !free)
            steal_d = (steal_q == PW'(NVOICE - 1)) ? '0 : steal_q + 1'b1;
      end else if (ev_off) begin
         gate_d = gate_q & ~match;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         on_q       <= 1'b0;
         key_q      <= '0;
         midi_clk_q <= 1'b0;
         steal_q    <= '0;
         gate_q     <= '0;
         note_q     <= '0;
         velo_q     <= '0;
      end else begin
         on_q       <= on_d;
         key_q      <= key_d;
         midi_clk_q <= midi_clk_d;
         steal_q    <= steal_d;
         gate_q     <= gate_d;
         note_q     <= note_d;
         velo_q     <= velo_d;
      end
   end

   assign midi_clk = midi_clk_q;
   assign gate_out = gate_q;
   assign note_out = note_q;
   assign velo_out = velo_q;
   assign busy_all = &gate_q;
endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed scoreboard bench for midi_voice_alloc: stimulus queues expected voice snapshots, monitor compares.
module tb_midi_voice_alloc;
   localparam int NV = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic midi_clk, busy_all;
   logic [NV-1:0]   gate_out;
   logic [7*NV-1:0] note_out, velo_out;

   midi_voice_alloc_if mi ();

   midi_voice_alloc #(.NVOICE(NV), .MIDI_CHAN(4'd2)) dut (
      .clk(clk), .rst(rst), .mi(mi), .midi_clk(midi_clk),
      .gate_out(gate_out), .note_out(note_out), .velo_out(velo_out), .busy_all(busy_all)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              id;
      logic [NV-1:0]   gate;
      logic [7*NV-1:0] note;
      logic [7*NV-1:0] velo;
      logic            busy;
      int              clks;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   clk_cnt = 0;
   logic chk_req = 1'b0;

   logic [NV-1:0] e_gate;
   logic [6:0]    e_note [NV];
   logic [6:0]    e_velo [NV];
   int            e_clks = 0;

   // Monitor: counts midi_clk pulses and checks each requested snapshot.
   always @(negedge clk) begin
      if (midi_clk) clk_cnt++;
      if (chk_req) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: snapshot requested with no expectation");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (gate_out !== e.gate) begin
               errors++;
               $display("FAIL gate#%0d: got %b want %b", e.id, gate_out, e.gate);
            end
            checks++;
            if (note_out !== e.note) begin
               errors++;
               $display("FAIL note#%0d: got %h want %h", e.id, note_out, e.note);
            end
            checks++;
            if (velo_out !== e.velo) begin
               errors++;
               $display("FAIL velo#%0d: got %h want %h", e.id, velo_out, e.velo);
            end
            checks++;
            if (busy_all !== e.busy) begin
               errors++;
               $display("FAIL busy#%0d: got %b want %b", e.id, busy_all, e.busy);
            end
            checks++;
            if (clk_cnt != e.clks) begin
               errors++;
               $display("FAIL midiclk#%0d: got %0d want %0d", e.id, clk_cnt, e.clks);
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      mi.midi_word  = b;
      mi.midi_valid = 1'b1;
      @(posedge clk); #1;
      mi.midi_valid = 1'b0;
   endtask

   task automatic note_msg(input logic [7:0] st, input logic [6:0] k, input logic [6:0] v);
      send(st); send({1'b0, k}); send({1'b0, v});
   endtask

   task automatic expect_snap(input int id);
      exp_t e;
      e.id = id;
      e.gate = e_gate;
      for (int i = 0; i < NV; i++) begin
         e.note[7*i +: 7] = e_note[i];
         e.velo[7*i +: 7] = e_velo[i];
      end
      e.busy = &e_gate;
      e.clks = e_clks;
      exp_q.push_back(e);
      chk_req = 1'b1;
      @(posedge clk); #1;
      chk_req = 1'b0;
   endtask

   task automatic model_reset();
      e_gate = '0;
      for (int i = 0; i < NV; i++) begin e_note[i] = '0; e_velo[i] = '0; end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      mi.midi_word  = 8'h00;
      mi.midi_valid = 1'b0;
      model_reset();
      @(posedge clk); #1;
      do_reset();
      expect_snap(0);

      // Basic note-on on channel 2
      note_msg(8'h92, 7'h3C, 7'h40);
      e_gate[0] = 1'b1; e_note[0] = 7'h3C; e_velo[0] = 7'h40;
      expect_snap(1);

      // Bare key/velocity pair: note-off only with running status
      send(8'h3C); send(8'h00);
`ifdef MIDI_RUNNING_STATUS_EN
      e_gate[0] = 1'b0;
`endif
      expect_snap(2);
      note_msg(8'h92, 7'h3C, 7'h00);
      e_gate[0] = 1'b0;
      expect_snap(3);

      // Timing clocks interleaved inside a message
      send(8'h92); send(8'hF8); send(8'h3C); send(8'hF8); send(8'h50);
      e_clks = 2;
      e_gate[0] = 1'b1; e_note[0] = 7'h3C; e_velo[0] = 7'h50;
      expect_snap(4);

      // Wrong channel, then status abort mid-message
      note_msg(8'h93, 7'h3D, 7'h40);
      expect_snap(5);
      send(8'h92); send(8'h3D); send(8'hB2); send(8'h40);
      expect_snap(6);

      // Fill all six voices, then steal round-robin
      do_reset();
      for (int k = 60; k < 66; k++) begin
         note_msg(8'h92, 7'(k), 7'(k - 40));
         e_gate[k-60] = 1'b1; e_note[k-60] = 7'(k); e_velo[k-60] = 7'(k - 40);
      end
      expect_snap(7);
      note_msg(8'h92, 7'd66, 7'h30);
      e_note[0] = 7'd66; e_velo[0] = 7'h30;
      expect_snap(8);
      note_msg(8'h92, 7'd67, 7'h31);
      e_note[1] = 7'd67; e_velo[1] = 7'h31;
      expect_snap(9);

      // Retrigger keeps the voice index
      note_msg(8'h92, 7'd63, 7'h7F);
      e_velo[3] = 7'h7F;
      expect_snap(10);

      // Note-off via 0x82, then one with no matching key
      note_msg(8'h82, 7'd64, 7'h22);
      e_gate[4] = 1'b0;
      expect_snap(11);
      note_msg(8'h82, 7'h50, 7'h00);
      expect_snap(12);

      // Lowest free voice is reused
      note_msg(8'h92, 7'd70, 7'h11);
      e_gate[4] = 1'b1; e_note[4] = 7'd70; e_velo[4] = 7'h11;
      expect_snap(13);

      // Reset between key and velocity discards the message
      send(8'h92); send(8'h3C);
      do_reset();
      expect_snap(14);
      send(8'h40);
      expect_snap(15);

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/midi_voice_alloc.md
MIDI_VOICE_ALLOC -- requirements
Module: midi_voice_alloc

Interface
REQ-001 Parameter NVOICE, default 6: number of voices, range 1..16.
REQ-002 Parameter MIDI_CHAN, default 4'd2: MIDI channel accepted (0..15).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 midi_word  input  8  received MIDI byte.
REQ-006 midi_valid  input  1  qualifies midi_word for exactly one clk cycle per byte.
REQ-007 midi_clk  output  1  one-cycle pulse per accepted 0xF8 timing clock.
REQ-008 gate_out  output  NVOICE  per-voice gate; 1 = note held.
REQ-009 note_out  output  7*NVOICE  per-voice key number; voice i occupies bits [7i+6:7i].
REQ-010 velo_out  output  7*NVOICE  per-voice note-on velocity, same packing as note_out.
REQ-011 busy_all  output  1  1 when every gate_out bit is 1.

Function
REQ-012 Byte classes: status = bit7 set and value < 0xF8; realtime = value >= 0xF8; data = bit7 clear.
REQ-013 A realtime byte SHALL NOT change parser state, running status or any voice; 0xF8 asserts midi_clk for the following cycle only.
REQ-014 Parser states: IDLE (no usable status), KEY (await key byte), VEL (await velocity byte), SKIP (discard data bytes).
REQ-015 Status 0x9n or 0x8n with n == MIDI_CHAN -> KEY, latching the message type; any other status -> SKIP. Status bytes 0xF0..0xF7 also clear running status.
REQ-016 Data byte in KEY -> latch key, go to VEL.
REQ-017 Data byte in VEL -> execute the event (REQ-018..REQ-021), then go to KEY under running status (see REQ-027).
REQ-018 Note-on with velocity 0 SHALL be processed as note-off.
REQ-019 Note-on allocation priority: (a) an active voice already holding the key is retriggered, keeping its index; else (b) the lowest-index voice with gate 0; else (c) the voice at steal_ptr, after which steal_ptr advances by 1 modulo NVOICE (wraps NVOICE-1 -> 0).
REQ-020 On note-on, the selected voice SHALL load note_out, velo_out and gate = 1.
REQ-021 On note-off, gate SHALL clear on every voice with gate = 1 and a matching note_out; note_out and velo_out hold their values; no match = no change.
REQ-022 Latency: outputs reflect an event on the first rising edge after the clk cycle in which the velocity byte is valid. At most one event per midi_valid.
REQ-023 Data bytes in IDLE or SKIP SHALL be ignored.
REQ-024 A status byte arriving in KEY or VEL aborts the partial message without touching any voice, then is decoded per REQ-015.
REQ-025 busy_all is combinational from gate_out.

Reset
REQ-026 While rst = 1 at a clk edge: parser to IDLE, running status cleared, steal_ptr = 0, gate_out = 0, note_out = 0, velo_out = 0, midi_clk = 0. rst mid-message discards the partial message. rst has priority over midi_valid in the same cycle.

Configuration
REQ-027 Macro MIDI_RUNNING_STATUS_EN. Defined: after VEL, parser returns to KEY, so further key/velocity pairs reuse the last status, and SKIP persists until the next status byte. Undefined: after VEL, parser returns to IDLE and every message requires its own status byte.

Verification
REQ-028 Send 0x92,0x3C,0x40 -> on the next edge, gate_out[0] = 1, note_out[0] = 0x3C, velo_out[0] = 0x40; other voices unchanged.
REQ-029 NVOICE = 6: seven note-ons with keys 60..66 -> voices 0..5 hold keys 60..65 and busy_all = 1; key 66 steals voice 0 and steal_ptr becomes 1.
REQ-030 Send 0x92,0x3C,0x40 then 0x3C,0x00 with MIDI_RUNNING_STATUS_EN defined -> gate_out[0] clears, note_out[0] stays 0x3C. With the macro undefined -> the second pair is ignored and gate_out[0] stays 1.
REQ-031 Send 0x92, 0xF8, 0x3C, 0xF8, 0x50 -> midi_clk pulses twice and voice 0 receives key 0x3C with velocity 0x50.
REQ-032 Send 0x93,0x3C,0x40 (wrong channel) -> no voice change. Then send 0x92,0x3C, 0xB2, 0x40 -> partial message aborted, no voice change.
REQ-033 Assert rst between the key byte and the velocity byte -> all outputs are 0 and the following velocity byte is ignored.
